axis_pattern_checker: RTL and testbench
=======================================

# axis_pattern_checker

AXI-Stream sink that consumes the incrementing byte-counter pattern produced by the team's pattern source and verifies it beat by beat. Every byte lane of a beat must carry the same 8-bit counter value, and that value must increase by one per accepted beat, wrapping modulo 256. The block counts beats and errors, captures the first mismatch, and optionally throttles `s_axis_tready` with an LFSR to exercise upstream backpressure. It sits at the far end of loopback and link tests as the checking terminus.

## Interface
- `DATA_WIDTH`, 32: stream width in bits; a multiple of 8, at least 8.
- `CNT_WIDTH`, 32: width of the beat and error counters.
- `aclk`  in  1  sole clock; all logic on the rising edge.
- `areset`  in  1  reset, asynchronous and active-high.
- `s_axis_tvalid`  in  1  upstream beat valid.
- `s_axis_tready`  out  1  registered ready.
- `s_axis_tdata`  in  DATA_WIDTH  payload.
- `s_axis_tkeep`  in  DATA_WIDTH/8  byte enables; must be all ones.
- `s_axis_tlast`  in  1  counted only, not checked.
- `throttle_en`  in  1  1 = LFSR-driven ready; 0 = ready held high.
- `clear`  in  1  synchronous pulse; returns the checker to UNLOCKED and zeroes all statistics.
- `locked`  out  1  high once a reference beat has been taken.
- `beat_cnt`  out  CNT_WIDTH  accepted beats; saturates.
- `err_cnt`  out  CNT_WIDTH  erroneous beats; saturates.
- `last_cnt`  out  CNT_WIDTH  accepted beats with `tlast` high; saturates.
- `err_flag`  out  1  sticky; set by the first error.
- `first_err_data`  out  DATA_WIDTH  `tdata` of the first erroneous beat.
- `first_err_exp`  out  8  expected counter value at the first error.

## Operation
- **Handshake.** A beat is accepted when `s_axis_tvalid && s_axis_tready`. The block never drops a beat it has signalled ready for.
- **Beat consistency.** A beat is *consistent* when all byte lanes equal `tdata[7:0]` and `tkeep` is all ones.
- **State UNLOCKED (reset state).**
  - First accepted beat: `expected <= tdata[7:0] + 1`, go to LOCKED, increment `beat_cnt`.
  - If that beat is inconsistent, it also counts as an error.
- **State LOCKED.** Each accepted beat is an error if it is inconsistent or if `tdata[7:0] != expected`.
  - On every accepted beat, error or not: `expected <= tdata[7:0] + 1` (mod 256). This resyncs after an error, so a single glitch costs exactly one error.
  - On an error, increment `err_cnt`.
  - On the first error since reset/clear: set `err_flag` and capture `first_err_data` and `first_err_exp`. Later errors do not overwrite the capture.
- **Counters.**
  - `beat_cnt` counts every accepted beat.
  - `last_cnt` counts every accepted beat with `tlast` high.
  - All counters saturate at all-ones; none wraps.
- **Arithmetic.**
  - `expected` is 8 bits; 255 + 1 = 0 is not an error.
  - The compare uses the low byte only for sequence checking; the other lanes are used only for consistency.
- **clear.**
  - Forces UNLOCKED and zeroes all counters, `err_flag` and the captures.
  - A beat accepted in the same cycle as `clear` is handshaked but discarded from statistics. `clear` wins.
- **Throttle.**
  - 16-bit Fibonacci LFSR, taps 16, 14, 13, 11, seed 0xACE1 at reset. It advances every cycle regardless of `throttle_en`.
  - Next ready: `!throttle_en | lfsr[0]`, registered into `s_axis_tready`.

## Timing
- **Reset values.**
  - `s_axis_tready` = 0, `locked` = 0, all counters = 0, `err_flag` = 0.
  - `first_err_data` = 0, `first_err_exp` = 0, state UNLOCKED, `expected` = 0, LFSR = 0xACE1.
- **Ready after reset.**
  - `s_axis_tready` rises on the first rising edge after `areset` deasserts, when `throttle_en` = 0.
  - A change on `throttle_en` takes effect on `s_axis_tready` one cycle later.
- **Statistics latency.**
  - All statistic outputs are registered and update on the edge that accepts the beat.
  - `locked` rises on the edge that accepts the first beat.
- **Reset mid-operation.** Asserting `areset` immediately drops ready and clears all state, with no wait for a packet boundary.
- **Throughput.** No bubbles are required: one beat per cycle is sustained with `throttle_en` = 0.

## Structure
- **Package `axis_pattern_pkg`:**
  - state enum `{UNLOCKED, LOCKED}`;
  - `LFSR_SEED = 16'hACE1`;
  - LFSR tap mask;
  - a function checking lane consistency for a given width.
- **Sub-module `axis_lfsr16`:** free-running 16-bit LFSR with async reset, seed from the package, output `lfsr[15:0]`.

## Test plan
- **Clean run.** Reset, `throttle_en` = 0, send 300 beats of 0x05050505 … wrapping through 0xFF to 0x30 → `beat_cnt` = 300, `err_cnt` = 0, `err_flag` = 0, `locked` = 1.
- **Single glitch.** Send 0x10101010, 0x11111111, 0x13131313, 0x14141414 → `err_cnt` = 1, `first_err_data` = 0x13131313, `first_err_exp` = 0x12, `beat_cnt` = 4.
- **Lane and keep errors.**
  - 0x20202120 mid-sequence → error, and the next beat 0x21212121 is error-free.
  - `tkeep` = 0b0111 on a correct beat → error.
- **Throttled, with clear.**
  - `throttle_en` = 1 with upstream always valid for 1000 cycles → `s_axis_tready` matches the LFSR bit-0 sequence from 0xACE1 delayed by one cycle, and beats accepted equal the count of ready-high cycles.
  - Continuing the same run: `clear` pulsed with a beat → counters read 0, `locked` = 0, and the next beat re-locks.
- **Saturation and reset.**
  - `CNT_WIDTH` = 4: 20 beats → `beat_cnt` = 15.
  - `areset` asserted mid-stream → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/axis_pattern_pkg.sv
// Shared types and helpers for the AXI-Stream incrementing-pattern checker.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   chk_state_e      - checker lock state (UNLOCKED / LOCKED)
//   LFSR_SEED        - reset value of the throttle LFSR
//   LFSR_TAPS        - feedback mask for the shift-right Fibonacci LFSR
//   lanes_consistent - all enabled lanes equal lane 0 and all keep bits set
package axis_pattern_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } chk_state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Polynomial taps 16,14,13,11 expressed for a right-shifting register:
    // tap k sits at bit (16-k), giving bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Widest stream the consistency helper supports (bits / bytes).
    localparam int unsigned MAX_DATA_BITS  = 1024;
    localparam int unsigned MAX_DATA_BYTES = MAX_DATA_BITS / 8;

    // True when every one of the low nbytes lanes equals lane 0 and every one
    // of the low nbytes keep bits is set. Callers zero-extend their buses.
    function automatic logic lanes_consistent(
        input logic [MAX_DATA_BITS-1:0]  data,
        input logic [MAX_DATA_BYTES-1:0] keep,
        input int unsigned               nbytes
    );
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < int'(MAX_DATA_BYTES); i++) begin
            if (i < int'(nbytes)) begin
                if (!keep[i]) begin
                    ok = 1'b0;
                end
                if (data[i*8 +: 8] != data[7:0]) begin
                    ok = 1'b0;
                end
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/axis_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used to throttle the stream ready.
// Latency: output is the register itself; it advances on every rising edge.
// Backpressure: none; it never stalls.
//
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset, loads LFSR_SEED
//   lfsr   - current LFSR state [15:0]
module axis_lfsr16
    import axis_pattern_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        fb;

    always_comb begin
        fb     = ^(lfsr_q & LFSR_TAPS);
        lfsr_d = {fb, lfsr_q[15:1]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/axis_pattern_checker.sv
// AXI-Stream sink verifying an incrementing byte-counter pattern; counts beats/errors, captures first error.
// Latency: all statistics registered, updated on the edge that accepts the beat; ready registered (1 cycle).
// Backpressure: ready held high, or driven by LFSR bit 0 when throttle_en; never drops a readied beat.
//
// Ports:
//   aclk, areset                 - clock, asynchronous active-high reset
//   s_axis_tvalid/tready/tdata/tkeep/tlast - stream sink
//   throttle_en                  - 1: LFSR-driven ready, 0: ready high
//   clear                        - synchronous pulse, back to UNLOCKED with zeroed statistics
//   locked                       - a reference beat has been taken
//   beat_cnt, err_cnt, last_cnt  - saturating counters
//   err_flag                     - sticky, set by the first error
//   first_err_data/first_err_exp - capture of the first erroneous beat
module axis_pattern_checker
    import axis_pattern_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic                    throttle_en,
    input  logic                    clear,
    output logic                    locked,
    output logic [CNT_WIDTH-1:0]    beat_cnt,
    output logic [CNT_WIDTH-1:0]    err_cnt,
    output logic [CNT_WIDTH-1:0]    last_cnt,
    output logic                    err_flag,
    output logic [DATA_WIDTH-1:0]   first_err_data,
    output logic [7:0]              first_err_exp
);

    localparam int unsigned          NBYTES  = DATA_WIDTH / 8;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // ------------------------------------------------------------------
    // Throttle source
    // ------------------------------------------------------------------
    logic [15:0] lfsr_w;
    logic [14:0] lfsr_hi_unused;

    axis_lfsr16 u_lfsr (
        .clk_i (aclk),
        .rst_i (areset),
        .lfsr  (lfsr_w)
    );

    // Only bit 0 gates ready; the upper bits matter only to the LFSR itself.
    assign lfsr_hi_unused = lfsr_w[15:1];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  tready_q,   tready_d;
    chk_state_e            state_q,    state_d;
    logic [7:0]            exp_q,      exp_d;
    logic [CNT_WIDTH-1:0]  beat_q,     beat_d;
    logic [CNT_WIDTH-1:0]  err_q,      err_d;
    logic [CNT_WIDTH-1:0]  last_q,     last_d;
    logic                  flag_q,     flag_d;
    logic [DATA_WIDTH-1:0] fdata_q,    fdata_d;
    logic [7:0]            fexp_q,     fexp_d;

    logic       accept;
    logic       consistent;
    logic [7:0] lane0;
    logic [7:0] cmp_ref;
    logic       beat_err;

    always_comb begin
        accept     = s_axis_tvalid && tready_q;
        lane0      = s_axis_tdata[7:0];
        consistent = lanes_consistent(MAX_DATA_BITS'(s_axis_tdata),
                                      MAX_DATA_BYTES'(s_axis_tkeep),
                                      NBYTES);

        // With no reference yet, the beat is its own reference: only lane
        // consistency can fail, and that lane value is what gets captured
        // as "expected" should it be the first error.
        cmp_ref  = (state_q == LOCKED) ? exp_q : lane0;
        beat_err = !consistent || (lane0 != cmp_ref);

        tready_d = !throttle_en || lfsr_w[0];

        state_d = state_q;
        exp_d   = exp_q;
        beat_d  = beat_q;
        err_d   = err_q;
        last_d  = last_q;
        flag_d  = flag_q;
        fdata_d = fdata_q;
        fexp_d  = fexp_q;

        if (clear) begin
            // A beat handshaked in this cycle is swallowed: clear wins.
            state_d = UNLOCKED;
            exp_d   = 8'd0;
            beat_d  = '0;
            err_d   = '0;
            last_d  = '0;
            flag_d  = 1'b0;
            fdata_d = '0;
            fexp_d  = 8'd0;
        end else if (accept) begin
            state_d = LOCKED;
            // Always resync to the received value so one glitch costs one error.
            exp_d   = lane0 + 8'd1;
            beat_d  = sat_inc(beat_q);
            if (s_axis_tlast) begin
                last_d = sat_inc(last_q);
            end
            if (beat_err) begin
                err_d = sat_inc(err_q);
                if (!flag_q) begin
                    flag_d  = 1'b1;
                    fdata_d = s_axis_tdata;
                    fexp_d  = cmp_ref;
                end
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            tready_q <= 1'b0;
            state_q  <= UNLOCKED;
            exp_q    <= 8'd0;
            beat_q   <= '0;
            err_q    <= '0;
            last_q   <= '0;
            flag_q   <= 1'b0;
            fdata_q  <= '0;
            fexp_q   <= 8'd0;
        end else begin
            tready_q <= tready_d;
            state_q  <= state_d;
            exp_q    <= exp_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
            last_q   <= last_d;
            flag_q   <= flag_d;
            fdata_q  <= fdata_d;
            fexp_q   <= fexp_d;
        end
    end

    assign s_axis_tready  = tready_q;
    assign locked         = (state_q == LOCKED);
    assign beat_cnt       = beat_q;
    assign err_cnt        = err_q;
    assign last_cnt       = last_q;
    assign err_flag       = flag_q;
    assign first_err_data = fdata_q;
    assign first_err_exp  = fexp_q;

endmodule

// File: tb/tb_axis_pattern_checker.sv
// Self-checking bench for axis_pattern_checker with a behavioural reference model.
// Two DUTs share stimulus: 32-bit counters and 4-bit counters (saturation).
// Outputs are compared against the model on every falling edge.
module tb_axis_pattern_checker;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        tvalid = 1'b0;
    logic [31:0] tdata = 32'h0;
    logic [3:0]  tkeep = 4'hF;
    logic        tlast = 1'b0;
    logic        throttle_en = 1'b0;
    logic        clear = 1'b0;

    logic        tready, locked, err_flag;
    logic [31:0] beat_cnt, err_cnt, last_cnt, fdata;
    logic [7:0]  fexp;

    logic        tready4, locked4, flag4;
    logic [3:0]  beat4, err4, last4;
    logic [31:0] fdata4;
    logic [7:0]  fexp4;

    always #5 aclk = ~aclk;

    axis_pattern_checker #(.DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tdata(tdata),
        .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
        .throttle_en(throttle_en), .clear(clear),
        .locked(locked), .beat_cnt(beat_cnt), .err_cnt(err_cnt), .last_cnt(last_cnt),
        .err_flag(err_flag), .first_err_data(fdata), .first_err_exp(fexp)
    );

    axis_pattern_checker #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut4 (
        .aclk(aclk), .areset(areset),
        .s_axis_tvalid(tvalid), .s_axis_tready(tready4), .s_axis_tdata(tdata),
        .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
        .throttle_en(throttle_en), .clear(clear),
        .locked(locked4), .beat_cnt(beat4), .err_cnt(err4), .last_cnt(last4),
        .err_flag(flag4), .first_err_data(fdata4), .first_err_exp(fexp4)
    );

    int n_checks = 0;
    int n_errs   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    bit          m_rdy    = 1'b0;
    logic [15:0] m_lfsr   = 16'hACE1;
    bit          m_locked = 1'b0;
    int          m_exp    = 0;
    longint      m_beats  = 0;
    longint      m_errs   = 0;
    longint      m_lasts  = 0;
    bit          m_flag   = 1'b0;
    logic [31:0] m_fdata  = 32'h0;
    logic [7:0]  m_fexp   = 8'h0;

    function automatic bit consistent(input logic [31:0] d, input logic [3:0] k);
        if (k != 4'hF) return 1'b0;
        for (int i = 1; i < 4; i++) begin
            if (d[8*i +: 8] != d[7:0]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // x^16 + x^14 + x^13 + x^11 + 1, shifting toward bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        logic fb;
        fb = x[0] ^ x[2] ^ x[3] ^ x[5];
        return {fb, x[15:1]};
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_rdy = 1'b0; m_lfsr = 16'hACE1; m_locked = 1'b0; m_exp = 0;
        m_beats = 0; m_errs = 0; m_lasts = 0;
        m_flag = 1'b0; m_fdata = 32'h0; m_fexp = 8'h0;
    endtask

    always @(posedge aclk or posedge areset) begin : model
        bit acc, err;
        int b0;
        if (areset) begin
            model_reset();
        end else begin
            acc    = tvalid && m_rdy;
            m_rdy  = !throttle_en || m_lfsr[0];
            m_lfsr = lfsr_next(m_lfsr);
            if (clear) begin
                m_locked = 1'b0; m_exp = 0;
                m_beats = 0; m_errs = 0; m_lasts = 0;
                m_flag = 1'b0; m_fdata = 32'h0; m_fexp = 8'h0;
            end else if (acc) begin
                b0 = int'(tdata[7:0]);
                m_beats++;
                if (tlast) m_lasts++;
                if (!m_locked) begin
                    err = !consistent(tdata, tkeep);
                    if (err && !m_flag) m_fexp = 8'(b0);
                end else begin
                    err = !consistent(tdata, tkeep) || (b0 != m_exp);
                    if (err && !m_flag) m_fexp = 8'(m_exp);
                end
                if (err) begin
                    m_errs++;
                    if (!m_flag) begin
                        m_flag  = 1'b1;
                        m_fdata = tdata;
                    end
                end
                m_exp    = (b0 + 1) % 256;
                m_locked = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle comparison
    // ------------------------------------------------------------------
    always @(negedge aclk) begin
        if (chk_en) begin
            chk("tready",     64'(tready),   64'(m_rdy));
            chk("locked",     64'(locked),   64'(m_locked));
            chk("beat_cnt",   64'(beat_cnt), 64'(sat(m_beats, 32)));
            chk("err_cnt",    64'(err_cnt),  64'(sat(m_errs, 32)));
            chk("last_cnt",   64'(last_cnt), 64'(sat(m_lasts, 32)));
            chk("err_flag",   64'(err_flag), 64'(m_flag));
            chk("first_data", 64'(fdata),    64'(m_fdata));
            chk("first_exp",  64'(fexp),     64'(m_fexp));
            chk("tready4",    64'(tready4),  64'(m_rdy));
            chk("beat_cnt4",  64'(beat4),    64'(sat(m_beats, 4)));
            chk("err_cnt4",   64'(err4),     64'(sat(m_errs, 4)));
            chk("last_cnt4",  64'(last4),    64'(sat(m_lasts, 4)));
            chk("first_exp4", 64'(fexp4),    64'(m_fexp));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus (all tasks start and end on a falling edge)
    // ------------------------------------------------------------------
    task automatic send(input logic [31:0] d, input logic [3:0] k, input bit last);
        int n;
        tdata = d; tkeep = k; tlast = last; tvalid = 1'b1;
        n = 0;
        while (!tready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        if (!tready) begin
            n_checks++;
            n_errs++;
            $display("FAIL send_timeout: ready stayed 0, expected 1 within 200 cycles");
        end
        @(negedge aclk);
        tvalid = 1'b0;
    endtask

    task automatic sendb(input logic [7:0] b);
        send({4{b}}, 4'hF, 1'b0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge aclk);
        clear = 1'b0;
        @(negedge aclk);
    endtask

    initial begin
        logic [7:0] seq;
        bit         acc;
        int         r;
        int         rdy_hits;
        int         n;

        repeat (3) @(negedge aclk);
        chk_en = 1'b1;
        chk("rst_tready",   64'(tready),   64'd0);
        chk("rst_locked",   64'(locked),   64'd0);
        chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        chk("rst_err_flag", 64'(err_flag), 64'd0);

        areset = 1'b0;
        @(negedge aclk);
        chk("ready_after_reset", 64'(tready), 64'd1);

        // Clean run 0x05 .. wrapping .. 0x30, tlast every 10th beat.
        for (int i = 0; i < 300; i++) begin
            seq = 8'(5 + i);
            send({4{seq}}, 4'hF, (i % 10) == 9);
        end
        chk("clean_beats",  64'(beat_cnt), 64'd300);
        chk("clean_errs",   64'(err_cnt),  64'd0);
        chk("clean_flag",   64'(err_flag), 64'd0);
        chk("clean_locked", 64'(locked),   64'd1);
        chk("clean_lasts",  64'(last_cnt), 64'd30);
        chk("sat_beats4",   64'(beat4),    64'd15);

        do_clear();
        chk("clear_beats",  64'(beat_cnt), 64'd0);
        chk("clear_locked", 64'(locked),   64'd0);

        // Single glitch.
        sendb(8'h10); sendb(8'h11); sendb(8'h13); sendb(8'h14);
        chk("glitch_errs",  64'(err_cnt),  64'd1);
        chk("glitch_data",  64'(fdata),    64'h13131313);
        chk("glitch_exp",   64'(fexp),     64'h12);
        chk("glitch_beats", 64'(beat_cnt), 64'd4);

        // Lane and keep errors.
        do_clear();
        sendb(8'h1E); sendb(8'h1F);
        send(32'h20202120, 4'hF, 1'b0);
        sendb(8'h21); sendb(8'h22);
        chk("lane_errs", 64'(err_cnt), 64'd1);
        chk("lane_data", 64'(fdata),   64'h20202120);
        chk("lane_exp",  64'(fexp),    64'h20);
        send(32'h23232323, 4'b0111, 1'b0);
        chk("keep_errs", 64'(err_cnt), 64'd2);
        sendb(8'h24);
        chk("keep_resync_errs", 64'(err_cnt),  64'd2);
        chk("keep_beats",       64'(beat_cnt), 64'd7);

        // Randomised traffic with glitches, keep errors, throttle and clears.
        do_clear();
        seq = 8'h60;
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) throttle_en = 1'($urandom_range(0, 1));
            tvalid = ($urandom_range(0, 3) != 0);
            r      = int'($urandom_range(0, 39));
            tdata  = {4{seq}};
            tkeep  = 4'hF;
            if (r == 0)      tdata[15:8] ^= 8'h04;
            else if (r == 1) tdata = {4{seq + 8'd3}};
            else if (r == 2) tkeep = 4'hE;
            tlast  = ($urandom_range(0, 7) == 0);
            clear  = ($urandom_range(0, 149) == 0);
            acc    = tvalid && tready;
            @(negedge aclk);
            if (acc) seq = tdata[7:0] + 8'd1;
        end
        clear = 1'b0; tvalid = 1'b0; tlast = 1'b0; tkeep = 4'hF;

        // Throttled, upstream always valid.
        throttle_en = 1'b1;
        do_clear();
        seq = 8'h40;
        rdy_hits = 0;
        tvalid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tdata = {4{seq}};
            acc   = tready;
            @(negedge aclk);
            if (acc) begin
                seq = seq + 8'd1;
                rdy_hits++;
            end
        end
        tdata = {4{seq}};
        chk("thr_beats_eq_ready", 64'(beat_cnt), 64'(rdy_hits));
        chk("thr_errs",           64'(err_cnt),  64'd0);

        // Clear coinciding with an accepted beat, then re-lock.
        n = 0;
        while (!tready && n < 100) begin
            @(negedge aclk);
            n++;
        end
        chk("thr_ready_seen", 64'(tready), 64'd1);
        clear = 1'b1;
        @(negedge aclk);
        clear = 1'b0;
        seq = seq + 8'd1;
        tdata = {4{seq}};
        chk("clr_beat_beats",  64'(beat_cnt), 64'd0);
        chk("clr_beat_locked", 64'(locked),   64'd0);
        n = 0;
        while (!locked && n < 100) begin
            acc = tready;
            @(negedge aclk);
            if (acc) begin
                seq = seq + 8'd1;
                tdata = {4{seq}};
            end
            n++;
        end
        chk("relock",       64'(locked),   64'd1);
        chk("relock_beats", 64'(beat_cnt), 64'd1);
        tvalid = 1'b0;

        // Asynchronous reset mid-stream, with an error recorded beforehand.
        throttle_en = 1'b0;
        @(negedge aclk);
        sendb(8'h50); sendb(8'h99);
        tdata = 32'h9A9A9A9A; tvalid = 1'b1;
        @(posedge aclk);
        #2 areset = 1'b1;
        #1;
        chk("arst_tready", 64'(tready),   64'd0);
        chk("arst_locked", 64'(locked),   64'd0);
        chk("arst_beats",  64'(beat_cnt), 64'd0);
        chk("arst_errs",   64'(err_cnt),  64'd0);
        chk("arst_lasts",  64'(last_cnt), 64'd0);
        chk("arst_flag",   64'(err_flag), 64'd0);
        chk("arst_fdata",  64'(fdata),    64'd0);
        chk("arst_fexp",   64'(fexp),     64'd0);
        chk("arst_beats4", 64'(beat4),    64'd0);
        tvalid = 1'b0;
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        repeat (3) @(negedge aclk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
